robot_cmd_sched: RTL and testbench

//  Command scheduler in front of the tracked-robot motor controller. Arbitrates timed move

---
 rtl/robot_cmd_sched.sv | 195 +++++++++++++++++++
 tb/tb_robot_cmd_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/robot_cmd_sched.sv
// Command scheduler for the tracked-robot motor controller: RC/AP arbitration, engine
// power sequencing, timed move hold with obstacle abort and an inter-command stop gap.
module robot_cmd_sched #(
  parameter int DUR_W    = 8,
  parameter int GAP_CYC  = 2,
  parameter int WAKE_TO  = 16,
  parameter int RC_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             pwr_req_i,
  input  logic             rc_valid_i,
  output logic             rc_ready_o,
  input  logic [2:0]       rc_cmd_i,
  input  logic [DUR_W-1:0] rc_dur_i,
  input  logic             ap_valid_i,
  output logic             ap_ready_o,
  input  logic [2:0]       ap_cmd_i,
  input  logic [DUR_W-1:0] ap_dur_i,
  output logic             motor_on_o,
  output logic [2:0]       move_o,
  input  logic             motor_status_i,
  input  logic             tracker_status_i,
  output logic             busy_o,
  output logic             grant_o,
  output logic             done_o,
  output logic             abort_o,
  output logic             fault_o
);

  localparam int WK_W = $clog2(WAKE_TO + 1);
  localparam int GP_W = $clog2(GAP_CYC + 1);
  localparam int BR_W = $clog2(RC_BURST + 1);
  localparam logic [2:0] MV_STOP = 3'b000;
  localparam logic [2:0] MV_FWD  = 3'b111;

  typedef enum logic [2:0] {S_OFF, S_WAKE, S_IDLE, S_RUN, S_GAP, S_STOP} state_t;

  state_t           state_q;
  logic [DUR_W-1:0] dur_q;
  logic [WK_W-1:0]  wake_q, wake_d;
  logic [GP_W-1:0]  gap_q;
  logic [BR_W-1:0]  burst_q, burst_d;
  logic             motor_on_q, rc_ready_q, ap_ready_q, busy_q, grant_q;
  logic             done_q, abort_q, fault_q;
  logic [2:0]       move_q;
  logic             rc_acc, ap_acc, pick_rc, pick_ap;

  // Ready is registered, so the grant for the next IDLE cycle is decided from the
  // burst count as it will stand after this cycle's accept.
  always_comb begin
    rc_acc  = (state_q == S_IDLE) && pwr_req_i && rc_valid_i && rc_ready_q;
    ap_acc  = (state_q == S_IDLE) && pwr_req_i && ap_valid_i && ap_ready_q;
    wake_d  = wake_q + 1'b1;
    burst_d = burst_q;
    if (!ap_valid_i || ap_acc)
      burst_d = '0;
    else if (rc_acc && (burst_q != BR_W'(RC_BURST)))
      burst_d = burst_q + 1'b1;
    pick_ap = ap_valid_i && (!rc_valid_i || (burst_d == BR_W'(RC_BURST)));
    pick_rc = rc_valid_i && !pick_ap;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_OFF;
      dur_q      <= '0;
      wake_q     <= '0;
      gap_q      <= '0;
      burst_q    <= '0;
      motor_on_q <= 1'b0;
      move_q     <= MV_STOP;
      rc_ready_q <= 1'b0;
      ap_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      burst_q    <= burst_d;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      rc_ready_q <= 1'b0;
      ap_ready_q <= 1'b0;
      case (state_q)
        S_OFF: begin
          motor_on_q <= 1'b0;
          move_q     <= MV_STOP;
          busy_q     <= 1'b0;
          if (!pwr_req_i) begin
            fault_q <= 1'b0;
          end else if (!fault_q) begin
            state_q    <= S_WAKE;
            motor_on_q <= 1'b1;
            wake_q     <= '0;
          end
        end
        S_WAKE: begin
          move_q <= MV_STOP;
          if (!pwr_req_i) begin
            state_q    <= S_STOP;
            motor_on_q <= 1'b0;
          end else if (motor_status_i) begin
            state_q    <= S_IDLE;
            rc_ready_q <= pick_rc;
            ap_ready_q <= pick_ap;
          end else if (wake_d == WK_W'(WAKE_TO)) begin
            state_q    <= S_OFF;
            motor_on_q <= 1'b0;
            fault_q    <= 1'b1;
            wake_q     <= '0;
          end else begin
            wake_q <= wake_d;
          end
        end
        S_IDLE: begin
          if (!pwr_req_i) begin
            state_q    <= S_STOP;
            motor_on_q <= 1'b0;
          end else if (rc_acc || ap_acc) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            grant_q <= ap_acc;
            move_q  <= ap_acc ? ap_cmd_i : rc_cmd_i;
            if (ap_acc) dur_q <= (ap_dur_i == '0) ? DUR_W'(1) : ap_dur_i;
            else        dur_q <= (rc_dur_i == '0) ? DUR_W'(1) : rc_dur_i;
          end else begin
            rc_ready_q <= pick_rc;
            ap_ready_q <= pick_ap;
          end
        end
        S_RUN: begin
          if (!pwr_req_i) begin
            state_q    <= S_STOP;
            motor_on_q <= 1'b0;
            move_q     <= MV_STOP;
            busy_q     <= 1'b0;
            abort_q    <= 1'b1;
          end else if (!motor_status_i) begin
            state_q <= S_WAKE;
            move_q  <= MV_STOP;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
            wake_q  <= '0;
          end else if ((move_q == MV_FWD) && tracker_status_i) begin
            state_q <= S_GAP;
            move_q  <= MV_STOP;
            abort_q <= 1'b1;
            gap_q   <= '0;
          end else if (dur_q == DUR_W'(1)) begin
            state_q <= S_GAP;
            move_q  <= MV_STOP;
            done_q  <= 1'b1;
            gap_q   <= '0;
          end else begin
            dur_q <= dur_q - 1'b1;
          end
        end
        S_GAP: begin
          if (!pwr_req_i) begin
            state_q    <= S_STOP;
            motor_on_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (gap_q == GP_W'(GAP_CYC - 1)) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            rc_ready_q <= pick_rc;
            ap_ready_q <= pick_ap;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_STOP: begin
          motor_on_q <= 1'b0;
          move_q     <= MV_STOP;
          busy_q     <= 1'b0;
          if (!motor_status_i) state_q <= S_OFF;
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign motor_on_o = motor_on_q;
  assign move_o     = move_q;
  assign rc_ready_o = rc_ready_q;
  assign ap_ready_o = ap_ready_q;
  assign busy_o     = busy_q;
  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign abort_o    = abort_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_robot_cmd_sched.sv
// Directed bench for robot_cmd_sched: cycle table for power-up and basic commands,
// plus sequences for burst arbitration, obstacle abort, power-down, wake timeout, reset.
module tb_robot_cmd_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       pwr = 1'b0, ms = 1'b0, ts = 1'b0;
  logic       rcv = 1'b0, apv = 1'b0;
  logic [2:0] rcc = '0, apc = '0;
  logic [7:0] rcd = '0, apd = '0;
  logic       rcr, apr, on, busy, grant, done, abort, fault;
  logic [2:0] mv;

  int n_vec = 0;
  int n_err = 0;

  robot_cmd_sched dut (
    .clk_i(clk), .rstn_i(rstn), .pwr_req_i(pwr),
    .rc_valid_i(rcv), .rc_ready_o(rcr), .rc_cmd_i(rcc), .rc_dur_i(rcd),
    .ap_valid_i(apv), .ap_ready_o(apr), .ap_cmd_i(apc), .ap_dur_i(apd),
    .motor_on_o(on), .move_o(mv), .motor_status_i(ms), .tracker_status_i(ts),
    .busy_o(busy), .grant_o(grant), .done_o(done), .abort_o(abort), .fault_o(fault)
  );

  always #5 clk = ~clk;

  // Expected output word: {on, move[2:0], rc_ready, ap_ready, busy, grant, done, abort, fault}
  typedef struct {
    logic       pwr, ms, rcv, apv;
    logic [2:0] rcc, apc;
    logic [7:0] rcd, apd;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic p, input logic m, input logic rv, input logic [2:0] rc,
                              input logic [7:0] rd, input logic av, input logic [2:0] ac,
                              input logic [7:0] ad, input logic [10:0] e);
    vec_t v;
    v.pwr = p; v.ms = m; v.rcv = rv; v.rcc = rc; v.rcd = rd;
    v.apv = av; v.apc = ac; v.apd = ad; v.exp = e;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {on, mv, rcr, apr, busy, grant, done, abort, fault};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit ap, input string nm);
    int c = 0;
    while (!(ap ? apr : rcr) && c < 20) begin
      cyc();
      c++;
    end
    check(nm, {10'd0, (ap ? apr : rcr)}, 11'd1);
  endtask

  vec_t tbl[28];
  logic exp_src[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1, 0, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_00_000);
    tbl[1]  = mk(1, 0, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_00_000);
    tbl[2]  = mk(1, 0, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_00_000);
    tbl[3]  = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_00_000);
    tbl[4]  = mk(1, 1, 1, 3'b110, 8'd5, 0, 3'b000, 8'd0, 11'b1_000_10_00_000);
    tbl[5]  = mk(1, 1, 1, 3'b110, 8'd5, 0, 3'b000, 8'd0, 11'b1_110_00_10_000);
    tbl[6]  = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_110_00_10_000);
    tbl[7]  = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_110_00_10_000);
    tbl[8]  = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_110_00_10_000);
    tbl[9]  = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_110_00_10_000);
    tbl[10] = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_10_100);
    tbl[11] = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_10_000);
    tbl[12] = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_10_00_000);
    tbl[13] = mk(1, 1, 1, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_10_000);
    tbl[14] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_10_100);
    tbl[15] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_10_000);
    tbl[16] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_00_000);
    tbl[17] = mk(1, 1, 0, 3'b000, 8'd0, 1, 3'b101, 8'd2, 11'b1_000_01_00_000);
    tbl[18] = mk(1, 1, 0, 3'b000, 8'd0, 1, 3'b101, 8'd2, 11'b1_101_00_11_000);
    tbl[19] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_101_00_11_000);
    tbl[20] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_11_100);
    tbl[21] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_11_000);
    tbl[22] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_01_000);
    tbl[23] = mk(1, 1, 1, 3'b100, 8'd1, 0, 3'b000, 8'd0, 11'b1_000_10_01_000);
    tbl[24] = mk(1, 1, 1, 3'b100, 8'd1, 0, 3'b000, 8'd0, 11'b1_100_00_10_000);
    tbl[25] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_10_100);
    tbl[26] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_10_000);
    tbl[27] = mk(1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0, 11'b1_000_00_00_000);

    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(), 11'b0_000_00_00_000);
    @(negedge clk);
    rstn = 1'b1;

    // Power-up, RC 110/5, RC 000/0, AP 101/2, invalid code 100/1
    for (int i = 0; i < 28; i++) begin
      pwr = tbl[i].pwr; ms = tbl[i].ms;
      rcv = tbl[i].rcv; rcc = tbl[i].rcc; rcd = tbl[i].rcd;
      apv = tbl[i].apv; apc = tbl[i].apc; apd = tbl[i].apd;
      cyc();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Burst arbitration with both sources continuously valid
    begin
      int g = 0;
      rcv = 1; rcc = 3'b101; rcd = 8'd1;
      apv = 1; apc = 3'b110; apd = 8'd1;
      for (int c = 0; c < 80 && g < 6; c++) begin
        cyc();
        check("never_both_ready", {10'd0, rcr & apr}, 11'd0);
        if (rcr || apr) begin
          check($sformatf("burst_src%0d", g), {10'd0, apr}, {10'd0, exp_src[g]});
          g++;
        end
      end
      check("burst_count", 11'(g), 11'd6);
      cyc();
      check("burst_last_grant", {10'd0, grant}, 11'd0);
      rcv = 0; apv = 0;
      repeat (4) cyc();
    end

    // Forward move aborted by obstacle on RUN cycle 3
    apv = 1; apc = 3'b111; apd = 8'd10;
    wait_rdy(1'b1, "fwd_ready");
    cyc();
    apv = 0;
    check("fwd_run1", outs(), 11'b1_111_00_11_000);
    cyc();
    check("fwd_run2", {8'd0, mv}, {8'd0, 3'b111});
    ts = 1;
    cyc();
    check("fwd_abort", outs(), 11'b1_000_00_11_010);
    ts = 0;
    cyc();
    check("fwd_abort_pulse", outs(), 11'b1_000_00_11_000);
    cyc();
    check("fwd_back_idle", {10'd0, busy}, 11'd0);

    // Same stimulus with a reverse-class code runs full duration
    apv = 1; apc = 3'b011; apd = 8'd10;
    wait_rdy(1'b1, "bwd_ready");
    cyc();
    apv = 0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("bwd_run%0d", k), {8'd0, mv}, {8'd0, 3'b011});
      if (k == 3) ts = 1;
      cyc();
    end
    check("bwd_done", outs(), 11'b1_000_00_11_100);
    ts = 0;
    repeat (2) cyc();

    // Power switch dropped mid-command
    rcv = 1; rcc = 3'b111; rcd = 8'd8;
    wait_rdy(1'b0, "pdn_ready");
    cyc();
    rcv = 0;
    cyc();
    pwr = 0;
    cyc();
    check("pdn_abort", outs(), 11'b0_000_00_00_010);
    cyc();
    check("pdn_stop_hold", outs(), 11'b0_000_00_00_000);
    ms = 0;
    cyc();
    check("pdn_off", outs(), 11'b0_000_00_00_000);

    // Wake timeout with engine never reporting
    pwr = 1;
    cyc();
    check("wake_start", outs(), 11'b1_000_00_00_000);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("wake_on%0d", k), {10'd0, on}, 11'd1);
      cyc();
    end
    check("wake_timeout", outs(), 11'b0_000_00_00_001);
    repeat (2) cyc();
    check("fault_sticky", outs(), 11'b0_000_00_00_001);
    pwr = 0;
    cyc();
    check("fault_clear", outs(), 11'b0_000_00_00_000);
    pwr = 1;
    cyc();
    check("repower_wake", outs(), 11'b1_000_00_00_000);
    ms = 1; rcv = 1; rcc = 3'b101; rcd = 8'd20;
    cyc();
    check("repower_idle", outs(), 11'b1_000_10_00_000);

    // Asynchronous reset mid-command
    cyc();
    rcv = 0;
    repeat (2) cyc();
    check("rst_pre", outs(), 11'b1_101_00_10_000);
    #2 rstn = 1'b0;
    #1;
    check("rst_async", outs(), 11'b0_000_00_00_000);
    @(negedge clk);
    rstn = 1'b1;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        cyc();
        seen = seen | done | abort;
      end
      check("rst_no_pulse", {10'd0, seen}, 11'd0);
    end
    check("rst_recover", outs(), 11'b1_000_00_00_000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
